// File: rtl/adder_share_ctrl.sv
// Round-robin sequencer for a shared A/B/C adder serving two requesters.
// Walks IDLE -> LDA -> LDB -> LDC -> DONE and reports the winner and the registered sum.
module adder_share_ctrl #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [1:0]   req_i,
  input  logic [W-1:0] a0_i,
  input  logic [W-1:0] b0_i,
  input  logic [W-1:0] a1_i,
  input  logic [W-1:0] b1_i,
  output logic [1:0]   gnt_o,
  output logic         busy_o,
  output logic         lda_o,
  output logic         ldb_o,
  output logic         ldc_o,
  output logic         done_o,
  output logic         done_id_o,
  output logic [W:0]   sum_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_LDC  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic         sel_q, last_q, win_s;
  logic [W-1:0] a_q, b_q;
  logic [W:0]   c_q;
  logic [1:0]   gnt_q;
  logic         busy_q, lda_q, ldb_q, ldc_q, done_q, done_id_q;

  function automatic logic [1:0] onehot(input logic s);
    return {s, ~s};
  endfunction

  // On a tie the requester that was not served last time wins.
  always_comb begin
    win_s = 1'b0;
    case (req_i)
      2'b01:   win_s = 1'b0;
      2'b10:   win_s = 1'b1;
      2'b11:   win_s = ~last_q;
      default: win_s = 1'b0;
    endcase
  end

  // Next-state selection; only IDLE waits, every other state advances unconditionally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_i != 2'b00) state_d = S_LDA;
        else                state_d = S_IDLE;
      end
      S_LDA:   state_d = S_LDB;
      S_LDB:   state_d = S_LDC;
      S_LDC:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath registers and outputs registered from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      lda_q     <= 1'b0;
      ldb_q     <= 1'b0;
      ldc_q     <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (req_i != 2'b00) begin
            sel_q     <= win_s;
            done_id_q <= win_s;
            last_q    <= win_s;
          end
        end
        S_LDA:   a_q <= sel_q ? a1_i : a0_i;
        S_LDB:   b_q <= sel_q ? b1_i : b0_i;
        S_LDC:   c_q <= {1'b0, a_q} + {1'b0, b_q};
        S_DONE:  c_q <= c_q;
        default: c_q <= c_q;
      endcase
      // Grant is taken from the live winner on entry to LDA, then from the latched select.
      if (state_d == S_IDLE)      gnt_q <= 2'b00;
      else if (state_q == S_IDLE) gnt_q <= onehot(win_s);
      else                        gnt_q <= onehot(sel_q);
      busy_q <= (state_d != S_IDLE);
      lda_q  <= (state_d == S_LDA);
      ldb_q  <= (state_d == S_LDB);
      ldc_q  <= (state_d == S_LDC);
      done_q <= (state_d == S_DONE);
    end
  end

  assign gnt_o     = gnt_q;
  assign busy_o    = busy_q;
  assign lda_o     = lda_q;
  assign ldb_o     = ldb_q;
  assign ldc_o     = ldc_q;
  assign done_o    = done_q;
  assign done_id_o = done_id_q;
  assign sum_o     = c_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_adder_share_ctrl;
  localparam int W = 8;

  logic         clk, rst_n;
  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   gnt;
  logic         busy, lda, ldb, ldc, done, done_id;
  logic [W:0]   sum;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  adder_share_ctrl #(.W(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req),
    .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
    .gnt_o(gnt), .busy_o(busy), .lda_o(lda), .ldb_o(ldb), .ldc_o(ldc),
    .done_o(done), .done_id_o(done_id), .sum_o(sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an operation is 4 busy cycles numbered 1..4 after the request edge.
  int         m_cyc;
  logic       m_id, m_last;
  logic [W-1:0] m_a, m_b;
  logic [W:0]   m_sum;

  function automatic logic pick(input logic [1:0] r, input logic last);
    if (r == 2'b11) return ~last;
    return r[1];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0; m_id <= 1'b0; m_last <= 1'b1;
      m_a <= '0; m_b <= '0; m_sum <= '0;
    end else if (m_cyc == 0) begin
      if (req != 2'b00) begin
        m_cyc  <= 1;
        m_id   <= pick(req, m_last);
        m_last <= pick(req, m_last);
      end
    end else begin
      if (m_cyc == 1) m_a <= m_id ? a1 : a0;
      if (m_cyc == 2) m_b <= m_id ? b1 : b0;
      if (m_cyc == 3) m_sum <= m_a + m_b + 9'd0;
      m_cyc <= (m_cyc == 4) ? 0 : m_cyc + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt",     32'(gnt),     (m_cyc != 0) ? 32'(m_id ? 2'b10 : 2'b01) : 32'd0);
      check("busy",    32'(busy),    32'(m_cyc != 0));
      check("lda",     32'(lda),     32'(m_cyc == 1));
      check("ldb",     32'(ldb),     32'(m_cyc == 2));
      check("ldc",     32'(ldc),     32'(m_cyc == 3));
      check("done",    32'(done),    32'(m_cyc == 4));
      check("done_id", 32'(done_id), 32'(m_id));
      check("sum",     32'(sum),     32'(m_sum));
    end
  end

  task automatic step();
    @(negedge clk); #2;
  endtask

  task automatic wait_done(input logic exp_id, input logic [W:0] exp_sum, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_id"},  32'(done_id), 32'(exp_id));
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    #2;
  endtask

  task automatic wait_ldb(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ldb) begin seen = 1'b1; break; end
    end
    check({tag, "_ldb_seen"}, 32'(seen), 32'd1);
    #2;
  endtask

  initial begin
    int nd;
    rst_n = 1'b0; req = 2'b11; a0 = 8'd1; b0 = 8'd2; a1 = 8'd3; b1 = 8'd4;
    step(); step();
    chk_en = 1'b1;
    // Reset holds everything idle even with both requests up.
    check("rst_gnt",  32'(gnt),  32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    rst_n = 1'b1;
    wait_done(1'b0, 9'd3, "t1");
    req = 2'b00;
    step();

    req = 2'b01; a0 = 8'h25; b0 = 8'h13;
    wait_done(1'b0, 9'h038, "t2");
    req = 2'b00;
    step();

    req = 2'b10; a1 = 8'hFF; b1 = 8'h01;
    wait_done(1'b1, 9'h100, "t3");
    req = 2'b00;
    step(); step(); step();
    check("t3_sum_hold", 32'(sum), 32'h100);

    req = 2'b11; a0 = 8'd4; b0 = 8'd6; a1 = 8'd15; b1 = 8'd5;
    wait_done(1'b0, 9'd10, "t4a");
    wait_done(1'b1, 9'd20, "t4b");
    wait_done(1'b0, 9'd10, "t4c");
    req = 2'b00;
    step();

    req = 2'b01; a0 = 8'd3; b0 = 8'd9;
    wait_ldb("t5");
    req = 2'b00;
    wait_done(1'b0, 9'd12, "t5");
    step();
    check("t5_idle", 32'(busy), 32'd0);

    req = 2'b01; a0 = 8'h40; b0 = 8'h40;
    wait_ldb("t6");
    rst_n = 1'b0; req = 2'b00;
    #1;
    check("t6_gnt", 32'(gnt), 32'd0);
    check("t6_sum", 32'(sum), 32'd0);
    step();
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("t6_no_done", 32'(nd), 32'd0);
    #2;
    req = 2'b01; a0 = 8'd3; b0 = 8'd4;
    wait_done(1'b0, 9'd7, "t6b");
    req = 2'b00;
    step();

    // Random traffic with operand churn and occasional resets.
    for (int i = 0; i < 600; i++) begin
      req   = 2'($urandom_range(0, 3));
      a0    = 8'($urandom); b0 = 8'($urandom);
      a1    = 8'($urandom); b1 = 8'($urandom);
      rst_n = ($urandom_range(0, 79) != 0);
      step();
    end
    rst_n = 1'b1; req = 2'b00;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
